// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-port word memory behind a request/response handshake
// with a programmable number of wait states before each access.
module dmem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH];

    logic              addr_err;
    logic [ADDR_W-1:0] mem_idx;
    logic              mem_we;

    // Misaligned or any address bit above the memory's byte range is an error.
    assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'd0);
    assign mem_idx  = addr_q[ADDR_W+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                err_d   = addr_err;
                mem_we  = wr_q && !addr_err;
                rdata_d = (!wr_q && !addr_err) ? mem_q[mem_idx] : 32'd0;
            end
            default: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        busy      = (state_q != S_IDLE);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder with WAIT_CYCLES=2 (d=0)
// and WAIT_CYCLES=0 (d=1) instances sharing clock and reset.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    int n_assert;
    int n_fail;

    dmem_responder #(.WAIT_CYCLES(2), .ADDR_W(6)) u_dut_w2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    dmem_responder #(.WAIT_CYCLES(0), .ADDR_W(6)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction; latency counts the acceptance cycle as cycle 0.
    task automatic txn(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int stall, input logic exp_err,
                       input logic [31:0] exp_rdata, input int exp_lat, input string tag);
        int          lat;
        logic [31:0] held_rdata;
        logic        held_err;
        @(negedge clk);
        check({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_write[d] = ~wr;
        req_addr[d]  = 32'h0000_0004;
        req_wdata[d] = 32'h5A5A_5A5A;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (rsp_valid[d]) lat = c;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rsp_rdata[d], exp_rdata);
        check({tag, "_err"}, 32'(rsp_err[d]), 32'(exp_err));
        held_rdata = rsp_rdata[d];
        held_err   = rsp_err[d];
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(rsp_valid[d]), 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata[d], held_rdata);
            check({tag, "_hold_err"}, 32'(rsp_err[d]), 32'(held_err));
            check({tag, "_hold_req_ready"}, 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        #1;
        check({tag, "_resp_req_ready"}, 32'(req_ready[d]), 32'd0);
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        @(negedge clk);
        check({tag, "_post_valid"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, "_post_rdata"}, rsp_rdata[d], 32'd0);
        check({tag, "_post_err"}, 32'(rsp_err[d]), 32'd0);
        check({tag, "_post_busy"}, 32'(busy[d]), 32'd0);
        check({tag, "_post_req_ready"}, 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            rsp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("init_req_ready", 32'(req_ready[0]), 32'd1);
        check("init_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("init_rdata", rsp_rdata[0], 32'd0);
        check("init_err", 32'(rsp_err[0]), 32'd0);
        check("init_busy", 32'(busy[0]), 32'd0);

        txn(0, 1'b0, 32'h0000_0020, 32'h0, 0, 1'b0, 32'h0, 4, "load_init_zero");
        txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 4, "store_10");
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 4, "load_10");
        txn(0, 1'b1, 32'h0000_0006, 32'h1111_2222, 0, 1'b1, 32'h0, 4, "store_misaligned");
        txn(0, 1'b0, 32'h0000_0004, 32'h0, 0, 1'b0, 32'h0, 4, "load_4");
        txn(0, 1'b0, 32'h0000_0100, 32'h0, 0, 1'b1, 32'h0, 4, "load_out_of_range");
        txn(0, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 0, 1'b0, 32'h0, 4, "store_top");
        txn(0, 1'b0, 32'h0000_00FC, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 4, "load_top");
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 5, 1'b0, 32'hDEAD_BEEF, 4, "backpressure");

        // Abort a store while it sits in WAIT; req_valid held high through reset.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h0000_0008;
        req_wdata[0] = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_busy_in_wait", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy_async", 32'(busy[0]), 32'd0);
        check("abort_rsp_valid_async", 32'(rsp_valid[0]), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_busy_rst_held", 32'(busy[0]), 32'd0);
        req_valid[0] = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("abort_no_response", 32'(rsp_valid[0]), 32'd0);
        end
        check("abort_req_ready", 32'(req_ready[0]), 32'd1);
        txn(0, 1'b0, 32'h0000_0008, 32'h0, 0, 1'b0, 32'h0, 4, "load_after_abort");
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 32'h0, 4, "load_10_after_rst");

        txn(1, 1'b1, 32'h0000_003C, 32'h1234_5678, 0, 1'b0, 32'h0, 2, "w0_store_3c");
        txn(1, 1'b0, 32'h0000_003C, 32'h0, 0, 1'b0, 32'h1234_5678, 2, "w0_load_3c");
        txn(1, 1'b0, 32'h0000_003D, 32'h0, 2, 1'b1, 32'h0, 2, "w0_load_misaligned");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
